// File: rtl/cnn_pkg.sv
// Shared fixed-point types, defaults and the saturate helper for the convolution datapath.
package cnn_pkg;
    localparam int NUM_WIDTH_DEF = 16;
    localparam int NUM_POINT_DEF = 8;
    localparam int ACC_WIDTH_DEF = 32;
    localparam int CNT_WIDTH_DEF = 12;

    typedef logic signed [NUM_WIDTH_DEF-1:0] num_t;
    typedef logic signed [ACC_WIDTH_DEF-1:0] acc_t;

    localparam acc_t NUM_MAX = acc_t'((64'sd1 <<< (NUM_WIDTH_DEF-1)) - 64'sd1);
    localparam acc_t NUM_MIN = acc_t'(-(64'sd1 <<< (NUM_WIDTH_DEF-1)));

    function automatic num_t saturate(input acc_t a);
        if (a > NUM_MAX)      return num_t'(NUM_MAX);
        else if (a < NUM_MIN) return num_t'(NUM_MIN);
        else                  return num_t'(a);
    endfunction
endpackage

// File: rtl/num_sat.sv
// Combinational saturate from the accumulator width down to NUM_WIDTH, with optional ReLU.
module num_sat
    import cnn_pkg::*;
#(
    parameter int NUM_WIDTH = NUM_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int RELU      = 1
) (
    input  logic [ACC_WIDTH-1:0] acc_i,
    output logic [NUM_WIDTH-1:0] num_o
);
    localparam logic signed [ACC_WIDTH-1:0] MAXV =
        {{(ACC_WIDTH-NUM_WIDTH+1){1'b0}}, {(NUM_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MINV =
        {{(ACC_WIDTH-NUM_WIDTH+1){1'b1}}, {(NUM_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] acc_s;
    logic [NUM_WIDTH-1:0]        sat;

    assign acc_s = acc_i;

    always_comb begin
        if (acc_s > MAXV)      sat = MAXV[NUM_WIDTH-1:0];
        else if (acc_s < MINV) sat = MINV[NUM_WIDTH-1:0];
        else                   sat = acc_i[NUM_WIDTH-1:0];
    end

    // ReLU acts after saturation, so a clamped negative still reads as zero.
    assign num_o = (RELU != 0 && sat[NUM_WIDTH-1]) ? '0 : sat;
endmodule

// File: rtl/group_accum.sv
// Accumulates cfg_nb signed partial sums (+bias on the first) into one saturated kernel result.
module group_accum
    import cnn_pkg::*;
#(
    parameter int NUM_WIDTH = NUM_WIDTH_DEF,
    parameter int NUM_POINT = NUM_POINT_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int RELU      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT_WIDTH-1:0] cfg_nb,
    input  logic [NUM_WIDTH-1:0] cfg_bias,
    input  logic [NUM_WIDTH-1:0] up_data,
    input  logic                 up_valid,
    output logic                 up_ready,
    output logic [NUM_WIDTH-1:0] dn_data,
    output logic                 dn_valid,
    input  logic                 dn_ready
);
    if (ACC_WIDTH < NUM_WIDTH + CNT_WIDTH || NUM_POINT >= NUM_WIDTH) begin : g_bad_cfg
        $error("group_accum: ACC_WIDTH too small or NUM_POINT out of range");
    end

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] nb_q, nb_d;
    logic [NUM_WIDTH-1:0] dn_data_q, dn_data_d;
    logic                 dn_valid_q, dn_valid_d;

    logic [ACC_WIDTH-1:0] acc_next, acc_base, bias_x, up_x;
    logic [CNT_WIDTH-1:0] nb_eff;
    logic [NUM_WIDTH-1:0] result;
    logic                 accept, first, last;

    assign up_ready = !dn_valid_q || dn_ready;
    assign accept   = up_valid && up_ready;
    assign first    = (count_q == '0);

    assign bias_x   = {{(ACC_WIDTH-NUM_WIDTH){cfg_bias[NUM_WIDTH-1]}}, cfg_bias};
    assign up_x     = {{(ACC_WIDTH-NUM_WIDTH){up_data[NUM_WIDTH-1]}}, up_data};
    assign acc_base = first ? bias_x : acc_q;
    assign acc_next = acc_base + up_x;

    // On the first term the live config decides the length; later terms use the latched copy.
    assign nb_eff   = first ? ((cfg_nb == '0) ? CNT_WIDTH'(1) : cfg_nb) : nb_q;
    assign last     = (count_q == nb_eff - CNT_WIDTH'(1));

    num_sat #(.NUM_WIDTH(NUM_WIDTH), .ACC_WIDTH(ACC_WIDTH), .RELU(RELU)) u_sat (
        .acc_i (acc_next),
        .num_o (result)
    );

    always_comb begin
        acc_d      = acc_q;
        count_d    = count_q;
        nb_d       = nb_q;
        dn_data_d  = dn_data_q;
        dn_valid_d = dn_valid_q && !dn_ready;
        if (accept) begin
            acc_d = acc_next;
            if (first) nb_d = nb_eff;
            if (last) begin
                count_d    = '0;
                dn_data_d  = result;
                dn_valid_d = 1'b1;
            end else begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q      <= '0;
            count_q    <= '0;
            nb_q       <= '0;
            dn_data_q  <= '0;
            dn_valid_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            count_q    <= count_d;
            nb_q       <= nb_d;
            dn_data_q  <= dn_data_d;
            dn_valid_q <= dn_valid_d;
        end
    end

    assign dn_data  = dn_data_q;
    assign dn_valid = dn_valid_q;
endmodule

// File: tb/tb_group_accum.sv
// Scoreboard bench for group_accum: two instances (ReLU on/off) share one stimulus stream.
module tb_group_accum;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] cfg_nb;
    logic [15:0] cfg_bias, up_data;
    logic        up_valid, dn_ready;
    logic        up_ready1, up_ready0, dn_valid1, dn_valid0;
    logic [15:0] dn_data1, dn_data0;

    int checks = 0;
    int errors = 0;
    logic [15:0] q1[$];
    logic [15:0] q0[$];

    always #5 clk = ~clk;

    group_accum #(.RELU(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_nb(cfg_nb), .cfg_bias(cfg_bias),
        .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready1),
        .dn_data(dn_data1), .dn_valid(dn_valid1), .dn_ready(dn_ready));

    group_accum #(.RELU(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cfg_nb(cfg_nb), .cfg_bias(cfg_bias),
        .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready0),
        .dn_data(dn_data0), .dn_valid(dn_valid0), .dn_ready(dn_ready));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: one pop per output fire, per instance.
    always @(negedge clk) begin
        if (rst_n && dn_valid1 && dn_ready) begin
            if (q1.size() == 0) chk("relu1 unexpected output", {16'h0, dn_data1}, 32'hDEAD);
            else chk("relu1 result", {16'h0, dn_data1}, {16'h0, q1.pop_front()});
        end
        if (rst_n && dn_valid0 && dn_ready) begin
            if (q0.size() == 0) chk("relu0 unexpected output", {16'h0, dn_data0}, 32'hDEAD);
            else chk("relu0 result", {16'h0, dn_data0}, {16'h0, q0.pop_front()});
        end
    end

    // Presents one term and returns #1 after the edge that accepted it.
    task automatic send(input logic [15:0] d);
        bit ok;
        int n;
        up_data  = d;
        up_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = up_ready1;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) chk("send timeout", 32'd0, 32'd1);
        up_valid = 1'b0;
    endtask

    task automatic expect_res(input logic [15:0] e1, input logic [15:0] e0);
        q1.push_back(e1);
        q0.push_back(e0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; cfg_nb = '0; cfg_bias = '0; up_data = '0; up_valid = 1'b0; dn_ready = 1'b1;
        @(posedge clk); #1;
        idle(2);
        chk("reset dn_valid", {31'd0, dn_valid1 | dn_valid0}, 32'd0);
        chk("reset dn_data1", {16'h0, dn_data1}, 32'h0);
        chk("reset dn_data0", {16'h0, dn_data0}, 32'h0);
        chk("reset up_ready", {31'd0, up_ready1 & up_ready0}, 32'd1);
        rst_n = 1'b1;
        idle(1);

        // Back-to-back pairs, each result valid the cycle after its second term.
        cfg_nb = 12'd2; cfg_bias = 16'h0;
        expect_res(16'h2400, 16'h2400);
        expect_res(16'h6400, 16'h6400);
        send(16'h0A00);
        send(16'h1A00);
        chk("pair1 latency", {31'd0, dn_valid1}, 32'd1);
        send(16'h2A00);
        chk("pair gap valid", {31'd0, dn_valid1}, 32'd0);
        send(16'h3A00);
        chk("pair2 latency", {31'd0, dn_valid1}, 32'd1);
        idle(2);

        // Positive then negative saturation.
        cfg_nb = 12'd5;
        expect_res(16'h7FFF, 16'h7FFF);
        send(16'h0A00); send(16'h1A00); send(16'h2A00); send(16'h3A00); send(16'h4A00);
        idle(1);
        expect_res(16'h0000, 16'h8000);
        send(16'hF600); send(16'hE600); send(16'hD600); send(16'hC600); send(16'hB600);
        idle(1);

        // nb=0 acts as 1, bias added on the single term.
        cfg_nb = 12'd0; cfg_bias = 16'h0100;
        expect_res(16'h0380, 16'h0380);
        send(16'h0280);
        chk("nb0 latency", {31'd0, dn_valid0}, 32'd1);
        idle(1);
        cfg_bias = 16'h0;
        expect_res(16'h0000, 16'hFF00);
        send(16'hFF00);
        idle(2);

        // Backpressure: result held, upstream stalled, then fire and accept in one cycle.
        cfg_nb = 12'd2; dn_ready = 1'b0;
        expect_res(16'h0300, 16'h0300);
        expect_res(16'h0900, 16'h0900);
        send(16'h0100);
        cfg_nb = 12'd7; cfg_bias = 16'h1000;
        send(16'h0200);
        up_data = 16'h0400; up_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp up_ready", {31'd0, up_ready1 | up_ready0}, 32'd0);
            chk("bp dn_data", {16'h0, dn_data1}, 32'h0300);
            chk("bp dn_valid", {31'd0, dn_valid1}, 32'd1);
        end
        cfg_nb = 12'd2; cfg_bias = 16'h0;
        @(posedge clk); #1;
        dn_ready = 1'b1;
        @(negedge clk);
        chk("bp release ready", {31'd0, up_ready1}, 32'd1);
        @(posedge clk); #1;
        up_valid = 1'b0;
        send(16'h0500);
        idle(2);

        // Reset mid-result leaves no residue.
        cfg_nb = 12'd3;
        send(16'h0700);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        expect_res(16'h0300, 16'h0300);
        send(16'h0100); send(16'h0100); send(16'h0100);
        idle(3);

        chk("relu1 queue drained", q1.size(), 32'd0);
        chk("relu0 queue drained", q0.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
